// File: rtl/alarm_ctrl_pkg.sv
// Shared types and constants for the alarm-set controller.
// The optional snooze feature is enabled by defining ALARM_SNOOZE_EN.
package alarm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SET    = 2'd1,
        RING   = 2'd2,
        SNOOZE = 2'd3
    } state_t;

    // BCD time packing: {h_tens, h_units, m_tens, m_units}
    localparam int H_TENS_W  = 3;
    localparam int H_UNITS_W = 4;
    localparam int M_TENS_W  = 3;
    localparam int M_UNITS_W = 4;
    localparam int TIME_W    = H_TENS_W + H_UNITS_W + M_TENS_W + M_UNITS_W;

    localparam logic FIELD_HOURS = 1'b1;
    localparam logic FIELD_MINS  = 1'b0;

endpackage

// File: rtl/alarm_set_controller_tick_timer.sv
// Loadable down-counter paced by tick_1hz; shared by the ring and snooze periods.
// done pulses on the tick that takes the count from 1 to 0.
module tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick_1hz,
    output logic         done
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (tick_1hz && (count_reg != '0)) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Independent of load so the FSM can reload on expiry without a comb loop
    assign done = tick_1hz && (count_reg == W'(1));

endmodule

// File: rtl/alarm_set_controller.sv
// Alarm mode/sequencing controller: button pulses to counter strobes, alarm match and ring timing.
// Define ALARM_SNOOZE_EN to add the btn_snooze input and the SNOOZE state.
module alarm_set_controller
    import alarm_ctrl_pkg::*;
#(
    parameter int RING_TICKS   = 60,
    parameter int SNOOZE_TICKS = 300
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic              btn_mode,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_stop,
`ifdef ALARM_SNOOZE_EN
    input  logic              btn_snooze,
`endif
    input  logic              armed,
    input  logic [TIME_W-1:0] cur_time,
    input  logic              cur_secs_zero,
    input  logic [TIME_W-1:0] alm_time,
    output logic              en_hours,
    output logic              en_mins,
    output logic              updown,
    output logic              set_mode,
    output logic              sel_hours,
    output logic              alarm_on
);

`ifdef ALARM_SNOOZE_EN
    localparam int TIMER_MAX = (SNOOZE_TICKS > RING_TICKS) ? SNOOZE_TICKS : RING_TICKS;
`else
    localparam int TIMER_MAX = RING_TICKS;
`endif
    localparam int TIMER_W = $clog2(TIMER_MAX + 1);

    state_t               state_reg;
    state_t               state_next;
    logic                 sel_hours_reg;
    logic                 en_hours_reg;
    logic                 en_mins_reg;
    logic                 updown_reg;
    logic                 alarm_on_reg;
    logic                 match_q_reg;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_val;
    logic                 timer_done;
    logic                 match;
    logic                 trigger;
    logic                 quit;

    // Registering the match makes the trigger fire once per matching minute
    assign match   = cur_secs_zero && (cur_time == alm_time);
    assign trigger = armed && match && !match_q_reg;
    assign quit    = btn_stop || btn_mode || !armed;

    tick_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .tick_1hz (tick_1hz),
        .done     (timer_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_load = 1'b0;
        timer_val  = TIMER_W'(RING_TICKS);
        case (state_reg)
            IDLE: begin
                if (btn_mode) begin
                    state_next = SET;
                end else if (trigger) begin
                    state_next = RING;
                    timer_load = 1'b1;
                end
            end
            SET: begin
                if (btn_mode) begin
                    state_next = IDLE;
                end
            end
            RING: begin
                if (quit) begin
                    state_next = IDLE;
`ifdef ALARM_SNOOZE_EN
                end else if (btn_snooze) begin
                    state_next = SNOOZE;
                    timer_load = 1'b1;
                    timer_val  = TIMER_W'(SNOOZE_TICKS);
`endif
                end else if (timer_done) begin
                    state_next = IDLE;
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (quit) begin
                    state_next = IDLE;
                end else if (timer_done) begin
                    state_next = RING;
                    timer_load = 1'b1;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        set_mode = (state_reg == SET);
    end

    // Field edits are dropped in the cycle that leaves SET
    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_hours_reg <= FIELD_HOURS;
            en_hours_reg  <= 1'b0;
            en_mins_reg   <= 1'b0;
            updown_reg    <= 1'b1;
            alarm_on_reg  <= 1'b0;
            match_q_reg   <= 1'b0;
        end else begin
            match_q_reg  <= match;
            alarm_on_reg <= (state_next == RING);
            en_hours_reg <= 1'b0;
            en_mins_reg  <= 1'b0;
            if ((state_reg == SET) && !btn_mode) begin
                if (btn_left && !btn_right) begin
                    sel_hours_reg <= FIELD_HOURS;
                end else if (btn_right && !btn_left) begin
                    sel_hours_reg <= FIELD_MINS;
                end
                if (btn_up ^ btn_down) begin
                    en_hours_reg <= (sel_hours_reg == FIELD_HOURS);
                    en_mins_reg  <= (sel_hours_reg == FIELD_MINS);
                    updown_reg   <= btn_up;
                end
            end
        end
    end

    assign en_hours  = en_hours_reg;
    assign en_mins   = en_mins_reg;
    assign updown    = updown_reg;
    assign sel_hours = sel_hours_reg;
    assign alarm_on  = alarm_on_reg;

endmodule
